// File: rtl/sr_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : sr_ff_bank
// Function : WIDTH-channel bank of set/reset storage elements. A runtime mode
//            register makes the S/R pins act as SR, JK, D or T inputs. Each
//            channel has a synchronous active-low preset and clear. SR
//            conflicts (S=R=1) resolve to a parameter-selected value and are
//            recorded in sticky per-channel flags and a saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module sr_ff_bank #(
  parameter int               WIDTH       = 8,
  parameter int               SR_CONFLICT = 0,
  parameter logic [WIDTH-1:0] INIT        = {WIDTH{1'b0}},
  parameter int               CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_mode_ld,
  input  logic [WIDTH-1:0] i_S,
  input  logic [WIDTH-1:0] i_R,
  input  logic [WIDTH-1:0] i_prn,
  input  logic [WIDTH-1:0] i_clrn,
  input  logic             i_conflict_clr,
  output logic [WIDTH-1:0] o_Q,
  output logic [WIDTH-1:0] o_Qn,
  output logic [1:0]       o_mode,
  output logic [WIDTH-1:0] o_changed,
  output logic [WIDTH-1:0] o_conflict,
  output logic [CNT_W-1:0] o_conflict_cnt
);

  localparam logic [1:0] c_MODE_SR = 2'b00;
  localparam logic [1:0] c_MODE_JK = 2'b01;
  localparam logic [1:0] c_MODE_D  = 2'b10;
  localparam logic [1:0] c_MODE_T  = 2'b11;

  // Popcount of up to 32 channels needs 6 bits; the sum is kept wide so
  // saturation is judged on the true total, never on a wrapped value.
  localparam int                 c_POP_W   = 6;
  localparam int                 c_SUM_W   = CNT_W + c_POP_W;
  localparam logic [CNT_W-1:0]   c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [c_SUM_W-1:0] c_MAX_EXT = {{c_POP_W{1'b0}}, c_CNT_MAX};

  logic [WIDTH-1:0]   r_q;
  logic [1:0]         r_mode;
  logic [WIDTH-1:0]   r_changed;
  logic [WIDTH-1:0]   r_conflict;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_q_next;
  logic [WIDTH-1:0]   w_evt;
  logic [c_POP_W-1:0] w_pop;
  logic [c_SUM_W-1:0] w_base;
  logic [c_SUM_W-1:0] w_sum;
  logic [CNT_W-1:0]   w_cnt_next;

  // Per-channel next state: preset, clear, enable gate, then mode function.
  always_comb begin
    w_q_next = r_q;
    w_evt    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      logic w_fn;
      w_fn = r_q[i];
      case (r_mode)
        c_MODE_SR: begin
          if (i_S[i] && i_R[i]) begin
            if (SR_CONFLICT == 1)      w_fn = 1'b1;
            else if (SR_CONFLICT == 2) w_fn = 1'b0;
            else if (SR_CONFLICT == 3) w_fn = ~r_q[i];
            else                       w_fn = r_q[i];
          end else if (i_S[i]) begin
            w_fn = 1'b1;
          end else if (i_R[i]) begin
            w_fn = 1'b0;
          end
        end
        c_MODE_JK: begin
          if (i_S[i] && i_R[i]) w_fn = ~r_q[i];
          else if (i_S[i])      w_fn = 1'b1;
          else if (i_R[i])      w_fn = 1'b0;
        end
        c_MODE_D: w_fn = i_S[i];
        c_MODE_T: w_fn = i_S[i] ? ~r_q[i] : r_q[i];
        default:  w_fn = r_q[i];
      endcase

      if (!i_prn[i])       w_q_next[i] = 1'b1;
      else if (!i_clrn[i]) w_q_next[i] = 1'b0;
      else if (i_en)       w_q_next[i] = w_fn;
      else                 w_q_next[i] = r_q[i];

      // Only an SR-mode, enabled, un-overridden S=R=1 counts as a conflict.
      w_evt[i] = (r_mode == c_MODE_SR) & i_en & i_prn[i] & i_clrn[i] & i_S[i] & i_R[i];
    end
  end

  // Number of conflict events on this edge.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + {{(c_POP_W-1){1'b0}}, w_evt[i]};
    end
  end

  // Counter next value: clear reloads with this cycle's events; saturate on the sum.
  always_comb begin
    w_base     = i_conflict_clr ? '0 : {{c_POP_W{1'b0}}, r_cnt};
    w_sum      = w_base + {{CNT_W{1'b0}}, w_pop};
    w_cnt_next = (w_sum > c_MAX_EXT) ? c_CNT_MAX : w_sum[CNT_W-1:0];
  end

  // Storage elements and their change strobe.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_q       <= INIT;
      r_changed <= '0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= w_q_next ^ r_q;
    end
  end

  // Mode register; a load takes effect on the following edge.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_mode <= c_MODE_SR;
    end else if (i_mode_ld) begin
      r_mode <= i_mode;
    end
  end

  // Sticky conflict flags; a same-cycle event survives a clear.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_conflict <= '0;
    end else if (i_conflict_clr) begin
      r_conflict <= w_evt;
    end else begin
      r_conflict <= r_conflict | w_evt;
    end
  end

  // Saturating conflict counter.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign o_Q            = r_q;
  assign o_Qn           = ~r_q;
  assign o_mode         = r_mode;
  assign o_changed      = r_changed;
  assign o_conflict     = r_conflict;
  assign o_conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sr_ff_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_ff_bank
// Function : Self-checking bench for sr_ff_bank: directed scenarios followed
//            by randomized cycles, compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_ff_bank;

  localparam int         W       = 8;
  localparam int         SR_RES  = 0;
  localparam logic [7:0] INIT_V  = 8'hA5;
  localparam int         CW      = 8;
  localparam int         CNT_MAX = (1 << CW) - 1;

  logic         clk;
  logic         rstn;
  logic         en;
  logic [1:0]   mode;
  logic         mode_ld;
  logic [W-1:0] S, R, prn, clrn;
  logic         cclr;
  logic [W-1:0] Q, Qn, changed, conflict;
  logic [1:0]   mode_o;
  logic [CW-1:0] cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [W-1:0] m_q;
  logic [1:0]   m_mode;
  logic [W-1:0] m_changed;
  logic [W-1:0] m_conf;
  int           m_cnt;

  sr_ff_bank #(
    .WIDTH(W), .SR_CONFLICT(SR_RES), .INIT(INIT_V), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_rstn(rstn), .i_en(en), .i_mode(mode), .i_mode_ld(mode_ld),
    .i_S(S), .i_R(R), .i_prn(prn), .i_clrn(clrn), .i_conflict_clr(cclr),
    .o_Q(Q), .o_Qn(Qn), .o_mode(mode_o), .o_changed(changed),
    .o_conflict(conflict), .o_conflict_cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behaviour of one channel under its mode, per the truth tables.
  function automatic logic fn_next(input logic [1:0] md, input logic q, input logic s, input logic r);
    case (md)
      2'd0: begin
        if (s && r) begin
          case (SR_RES)
            1: return 1'b1;
            2: return 1'b0;
            3: return ~q;
            default: return q;
          endcase
        end
        if (s) return 1'b1;
        if (r) return 1'b0;
        return q;
      end
      2'd1: begin
        if (s && r) return ~q;
        if (s) return 1'b1;
        if (r) return 1'b0;
        return q;
      end
      2'd2: return s;
      default: return s ? ~q : q;
    endcase
  endfunction

  // One clock: predict from current inputs, take the edge, compare all outputs.
  task automatic cycle(input string tag);
    logic [W-1:0] n_q;
    logic [W-1:0] n_conf;
    logic [W-1:0] evt;
    int           nev;
    int           n_cnt;
    logic [1:0]   n_mode;
    nev = 0;
    evt = '0;
    for (int c = 0; c < W; c++) begin
      if (!prn[c])       n_q[c] = 1'b1;
      else if (!clrn[c]) n_q[c] = 1'b0;
      else if (!en)      n_q[c] = m_q[c];
      else               n_q[c] = fn_next(m_mode, m_q[c], S[c], R[c]);
      if (m_mode == 2'd0 && en && prn[c] && clrn[c] && S[c] && R[c]) begin
        evt[c] = 1'b1;
        nev++;
      end
    end
    n_conf = cclr ? evt : (m_conf | evt);
    n_cnt  = (cclr ? 0 : m_cnt) + nev;
    if (n_cnt > CNT_MAX) n_cnt = CNT_MAX;
    n_mode = mode_ld ? mode : m_mode;

    @(posedge clk);
    #1;
    if (!rstn) begin
      m_changed = '0;
      m_q       = INIT_V;
      m_mode    = 2'd0;
      m_conf    = '0;
      m_cnt     = 0;
    end else begin
      m_changed = n_q ^ m_q;
      m_q       = n_q;
      m_mode    = n_mode;
      m_conf    = n_conf;
      m_cnt     = n_cnt;
    end
    chk({tag, ".Q"},        {24'd0, Q},        {24'd0, m_q});
    chk({tag, ".Qn"},       {24'd0, Qn},       {24'd0, ~m_q});
    chk({tag, ".mode"},     {30'd0, mode_o},   {30'd0, m_mode});
    chk({tag, ".changed"},  {24'd0, changed},  {24'd0, m_changed});
    chk({tag, ".conflict"}, {24'd0, conflict}, {24'd0, m_conf});
    chk({tag, ".cnt"},      {24'd0, cnt},      m_cnt);
  endtask

  initial begin
    m_q = INIT_V; m_mode = 2'd0; m_changed = '0; m_conf = '0; m_cnt = 0;
    rstn = 1'b0; en = 1'b0; mode = 2'd0; mode_ld = 1'b0;
    S = '0; R = '0; prn = '1; clrn = '1; cclr = 1'b0;

    // Reset, then idle SR inputs: state must sit at INIT
    cycle("rst0");
    cycle("rst1");
    chk("rst.Q_lit", {24'd0, Q}, 32'hA5);
    rstn = 1'b1; en = 1'b1;
    for (int k = 0; k < 3; k++) cycle("idle");
    chk("idle.Qn_lit", {24'd0, Qn}, 32'h5A);

    // SR set on upper nibble, conflicts on lower nibble
    S = 8'hFF; R = 8'h0F;
    cycle("sr_first");
    chk("sr.Q_lit", {24'd0, Q}, 32'hF5);
    chk("sr.conf_lit", {24'd0, conflict}, 32'h0F);
    chk("sr.cnt_lit", {24'd0, cnt}, 32'd4);
    for (int k = 1; k < 70; k++) cycle("sr_sat");
    chk("sr.sat_lit", {24'd0, cnt}, 32'd255);

    // Load JK while S=R=1: load edge still uses SR, then toggle every edge
    S = 8'hFF; R = 8'hFF; mode = 2'd1; mode_ld = 1'b1;
    cycle("jk_load");
    mode_ld = 1'b0;
    cclr = 1'b1;
    cycle("jk_tog_clr");
    cclr = 1'b0;
    for (int k = 0; k < 4; k++) cycle("jk_tog");
    chk("jk.changed_lit", {24'd0, changed}, 32'hFF);
    chk("jk.cnt_lit", {24'd0, cnt}, 32'd0);

    // D mode with preset beating clear on channel 0
    mode = 2'd2; mode_ld = 1'b1;
    cycle("d_load");
    mode_ld = 1'b0; S = 8'h00; R = 8'h00; prn = 8'hFE; clrn = 8'hFE;
    cycle("d_pc");
    chk("d.Q_lit", {24'd0, Q}, 32'h01);
    en = 1'b0; S = 8'hFF;
    cycle("d_pc_noen");
    en = 1'b1; prn = 8'hFF; clrn = 8'hFF; S = 8'h3C;
    cycle("d_plain");

    // T mode with enable alternating
    mode = 2'd3; mode_ld = 1'b1; S = 8'h00;
    cycle("t_load");
    mode_ld = 1'b0; S = 8'h01;
    for (int k = 0; k < 6; k++) begin
      en = (k % 2 == 0);
      cycle("t_tog");
    end

    // Back to SR; clear coincident with a conflict on channel 2
    en = 1'b1; S = 8'h00; mode = 2'd0; mode_ld = 1'b1;
    cycle("sr_load");
    mode_ld = 1'b0; S = 8'h04; R = 8'h04; cclr = 1'b1;
    cycle("clr_evt");
    chk("clr.conf_lit", {24'd0, conflict}, 32'h04);
    chk("clr.cnt_lit", {24'd0, cnt}, 32'd1);
    cclr = 1'b0; S = 8'hF0; R = 8'h00;
    cycle("pre_rst");

    // Mid-sequence reset discards everything pending on that edge
    rstn = 1'b0; mode = 2'd1; mode_ld = 1'b1; prn = 8'h00; cclr = 1'b1;
    cycle("mid_rst");
    chk("mid_rst.Q_lit", {24'd0, Q}, 32'hA5);
    rstn = 1'b1; mode_ld = 1'b0; prn = 8'hFF; cclr = 1'b0; S = '0; R = '0;
    cycle("post_rst");

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rstn    = ($urandom_range(0, 59) != 0);
      en      = ($urandom_range(0, 3) != 0);
      mode_ld = ($urandom_range(0, 7) == 0);
      mode    = 2'($urandom);
      S       = 8'($urandom);
      R       = 8'($urandom);
      prn     = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
      clrn    = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
      cclr    = ($urandom_range(0, 15) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sr_ff_bank.md
# sr_ff_bank

Parametrised bank of WIDTH set/reset storage elements that succeeds the single-bit SR flip-flop. Each channel has its own synchronous active-low preset and clear. A runtime-selectable mode makes the same S/R pins behave as SR, JK, D or T inputs. SR conflicts (S=R=1) resolve to a defined value set by parameter instead of X, and conflicts are recorded in per-channel sticky flags and a saturating counter. The bank serves as the general-purpose control/status flag register for datapath blocks.

## Interface
- WIDTH, 8, number of channels (1..32)
- SR_CONFLICT, 0, SR-mode result for S=R=1: 0 hold, 1 set, 2 reset, 3 toggle
- INIT, {WIDTH{1'b0}}, value loaded into o_Q on reset
- CNT_W, 8, width of the conflict counter
- i_clk  in  1  clock; all state updates on the rising edge
- i_rstn  in  1  reset, synchronous, active-low
- i_en  in  1  function enable; gates S/R action only, not preset/clear
- i_mode  in  2  mode request: 00 SR, 01 JK, 10 D, 11 T
- i_mode_ld  in  1  loads i_mode into the mode register
- i_S  in  WIDTH  S / J / D / T input per channel
- i_R  in  WIDTH  R / K input per channel; ignored in D and T modes
- i_prn  in  WIDTH  per-channel preset, active-low, forces Q=1
- i_clrn  in  WIDTH  per-channel clear, active-low, forces Q=0
- i_conflict_clr  in  1  clears the sticky flags and the counter
- o_Q  out  WIDTH  stored state
- o_Qn  out  WIDTH  ~o_Q, combinational
- o_mode  out  2  current mode register
- o_changed  out  WIDTH  one-cycle pulse per channel whose Q changed on the last edge
- o_conflict  out  WIDTH  sticky SR-conflict flag per channel
- o_conflict_cnt  out  CNT_W  saturating count of SR-conflict events

## Operation
- Per-channel next-Q priority, highest first:
  1. i_rstn=0: Q=INIT.
  2. i_prn[i]=0: Q=1. Preset wins over clear when both are low.
  3. i_clrn[i]=0: Q=0.
  4. i_en=0: hold.
  5. Mode function below.
- SR: 00 hold, 01 Q=0, 10 Q=1, 11 resolved by SR_CONFLICT. Never produces X.
- JK: 00 hold, 01 Q=0, 10 Q=1, 11 toggle.
- D: Q=S.
- T: S=1 toggles, S=0 holds.
- Mode register:
  - Reset value 00 (SR).
  - Loads on i_mode_ld=1, independent of i_en.
  - The new mode governs the edge after the load edge; the load-edge update uses the old mode.
- Conflict event on channel i: mode reg=SR, i_en=1, i_prn[i]=1, i_clrn[i]=1, S[i]=R[i]=1. JK 11 is never a conflict.
- Sticky flags: o_conflict[i] sets on an event. i_conflict_clr=1 clears all flags; a same-cycle event wins for that channel (flag stays 1).
- Counter:
  - Adds popcount(events) each cycle and saturates at 2^CNT_W-1; it never wraps.
  - i_conflict_clr=1 loads the counter with that cycle's popcount (normally 0).
- o_changed[i]: registered (Q_next != Q), high for the one cycle after the edge on which Q changed.

## Timing
- Every register updates on the rising edge of i_clk; there is no asynchronous path.
- Latency: input to o_Q is one edge. o_Qn follows o_Q combinationally. o_changed, o_conflict and o_conflict_cnt are aligned with the o_Q they describe.
- Reset values: o_Q=INIT, o_Qn=~INIT, o_mode=00, o_changed=0, o_conflict=0, o_conflict_cnt=0.
- Reset asserted mid-operation discards all pending inputs on that edge, including i_mode_ld, preset/clear and i_conflict_clr. Reset does not pulse o_changed.
- Reset is the only global clear; i_conflict_clr does not affect o_Q or the mode register.
- Counter saturation is evaluated on the sum: at 2^CNT_W-2, an event count of 3 yields 2^CNT_W-1.

## Test plan
- Reset with INIT=8'hA5, then apply 8'h00 S/R for 3 cycles -> o_Q=8'hA5, o_Qn=8'h5A, o_mode=00, o_changed=0, counter=0 throughout.
- SR mode, SR_CONFLICT=0, S=8'hFF, R=8'h0F, en=1 -> o_Q[7:4]=1, o_Q[3:0] hold; o_conflict=8'h0F; counter=4. Repeat 70 cycles with CNT_W=8 -> counter saturates at 255.
- Mode load to JK (01) while S=R=8'hFF -> load edge applies the SR conflict rule; following edges toggle o_Q every cycle with o_changed=8'hFF; counter stops incrementing.
- D mode: i_prn=8'hFE, i_clrn=8'hFE, S=8'h00 -> o_Q[0]=1 (preset beats clear) and o_Q[7:1]=0; with en=0 the preset still applies.
- T mode, S=8'h01, en toggling 1/0 -> o_Q[0] flips only on en=1 edges; o_changed[0] pulses exactly one cycle after each flip.
- i_conflict_clr in the same cycle as an SR conflict on channel 2 -> o_conflict=8'h04, counter=1; i_rstn low mid-sequence -> all outputs return to reset values on the next edge.
